// File: rtl/apb_defs.sv
// apb_defs: state encoding, default widths and UART register offsets shared by the APB bridge files
package apb_defs;
  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_BUS_WIDTH = 16;
  localparam int APB_ADDR_WRITE = 0;
  localparam int APB_ADDR_READ = 1;
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;
  function automatic int timer_width(input int cycles);
    return cycles < 1 ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating ACCESS wait-state counter with an expiry pulse at TIMEOUT_CYCLES
module apb_wait_timer
  import apb_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (count_en && count != LIMIT) count <= count + 1'b1;
  end
  // fires on the wait cycle that would bring the count up to the limit
  assign expired = (TIMEOUT_CYCLES != 0) && count_en && (count == LIMIT - 1'b1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request to APB SETUP/ACCESS initiator with wait-state timeout
module apb_master_bridge
  import apb_defs::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int BUS_WIDTH = APB_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [BUS_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [BUS_WIDTH-1:0]  M_PWDATA,
  input  logic [BUS_WIDTH-1:0]  M_PRDATA,
  input  logic                  M_PREADY
);
  apb_state_e state, state_next;
  logic ready, handshake, expired, done;
  // a floating or unknown PREADY must never complete a transfer
  assign ready = M_PREADY === 1'b1;
  assign handshake = req_valid && req_ready;
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .clear(handshake),
    .count_en(state == APB_ACCESS && !ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= APB_IDLE;
    else state <= state_next;
  end
  always_comb begin
    req_ready = reset_n && state == APB_IDLE;
    M_PSELx = state != APB_IDLE;
    M_PENABLE = state == APB_ACCESS;
    done = state == APB_ACCESS && (ready || expired);
    state_next = state == APB_IDLE ? (req_valid && reset_n ? APB_SETUP : APB_IDLE) :
                 state == APB_SETUP ? APB_ACCESS :
                 done ? APB_IDLE : APB_ACCESS;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      M_PADDR <= '0;
      M_PWRITE <= 1'b0;
      M_PWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (handshake) begin
        M_PADDR <= req_addr;
        M_PWRITE <= req_write;
        M_PWDATA <= req_wdata;
      end
      rsp_valid <= done;
      rsp_err <= done && !ready;
      rsp_rdata <= done && ready && !M_PWRITE ? M_PRDATA : '0;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized scoreboard bench for the APB bridge with a wait-state slave model
module tb_apb_master_bridge;
  import apb_defs::*;
  localparam int TO = 8;
  localparam int LONG_WAIT = 2000;
  typedef struct { int due; logic err; logic [15:0] rdata; } rsp_t;
  typedef struct { logic [15:0] addr; logic write; logic [15:0] wdata; int w; logic [15:0] prdata; } acc_t;
  logic clk = 0, reset_n = 1;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic [15:0] M_PADDR, M_PWDATA, M_PRDATA;
  logic M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;
  logic z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_err;
  logic [15:0] z_req_addr, z_req_wdata, z_rsp_rdata, z_paddr, z_pwdata, z_prdata;
  logic z_pwrite, z_psel, z_penable, z_pready;
  int cyc = 0, checks = 0, errors = 0;
  rsp_t sb[$];
  acc_t sq[$];
  int prev_hs = 0, prev_lat = 0;
  bit have_prev = 0;
  apb_master_bridge #(.ADDR_WIDTH(16), .BUS_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );
  apb_master_bridge #(.ADDR_WIDTH(16), .BUS_WIDTH(16), .TIMEOUT_CYCLES(0)) dut_nto (
    .clk(clk), .reset_n(reset_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_addr(z_req_addr), .req_write(z_req_write), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .M_PADDR(z_paddr), .M_PWRITE(z_pwrite), .M_PSELx(z_psel), .M_PENABLE(z_penable),
    .M_PWDATA(z_pwdata), .M_PRDATA(z_prdata), .M_PREADY(z_pready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // response monitor: pops the scoreboard on every rsp_valid pulse
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end else begin
      chk("idle_rsp_err", rsp_err, 0);
      chk("idle_rsp_rdata", rsp_rdata, 0);
    end
  end
  // slave model: holds PREADY low for w ACCESS cycles, random PREADY outside ACCESS
  acc_t cur = '{16'h0, 1'b0, 16'h0, 0, 16'h0};
  int acc_n = 0;
  always @(negedge clk) begin
    if (M_PSELx && M_PENABLE) begin
      if (acc_n == 0) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got ACCESS expected none (cycle %0d)", cyc);
        end else cur = sq.pop_front();
      end
      chk("paddr", M_PADDR, cur.addr);
      chk("pwrite", M_PWRITE, cur.write);
      chk("pwdata", M_PWDATA, cur.wdata);
      M_PREADY = acc_n == cur.w;
      M_PRDATA = acc_n == cur.w ? cur.prdata : 16'($urandom);
      acc_n++;
    end else begin
      acc_n = 0;
      M_PREADY = 1'($urandom);
      M_PRDATA = 16'($urandom);
    end
  end
  int z_acc = 0;
  always @(negedge clk) begin
    if (z_psel && z_penable) begin
      z_pready = z_acc == LONG_WAIT;
      z_prdata = z_acc == LONG_WAIT ? 16'h5A3C : 16'($urandom);
      z_acc++;
    end else begin
      z_acc = 0;
      z_pready = 1'b0;
    end
  end
  task automatic issue(input logic [15:0] a, input logic wr, input logic [15:0] wd, input int w,
                       input logic [15:0] pd, input int gap);
    int budget, hs, lat;
    rsp_t e;
    acc_t s;
    budget = 0;
    repeat (gap) begin
      req_valid = 0;
      req_addr = 16'($urandom);
      req_write = 1'($urandom);
      req_wdata = 16'($urandom);
      @(negedge clk);
    end
    req_valid = 1;
    req_addr = a;
    req_write = wr;
    req_wdata = wd;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 0;
      return;
    end
    hs = cyc + 1;
    lat = w < TO ? 2 + w : 1 + TO;
    if (gap == 0 && have_prev) chk("b2b_handshake", hs, prev_hs + prev_lat + 1);
    prev_hs = hs;
    prev_lat = lat;
    have_prev = 1;
    e = '{hs + lat, w >= TO, (w < TO && !wr) ? pd : 16'h0};
    s = '{a, wr, wd, w, pd};
    sb.push_back(e);
    sq.push_back(s);
    @(negedge clk);
  endtask
  task automatic drain();
    int n;
    n = 0;
    req_valid = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int n, hsz;
    req_valid = 0; req_addr = 0; req_write = 0; req_wdata = 0;
    M_PREADY = 0; M_PRDATA = 0;
    z_req_valid = 0; z_req_addr = 0; z_req_write = 0; z_req_wdata = 0;
    z_pready = 0; z_prdata = 0;
    #1 reset_n = 0;
    #2;
    chk("reset_psel", M_PSELx, 0);
    chk("reset_penable", M_PENABLE, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_paddr", M_PADDR, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    #1 chk("ready_after_reset", req_ready, 1);
    @(negedge clk);
    issue(16'(APB_ADDR_WRITE), 1'b1, 16'h0041, 0, 16'hFFFF, 0);
    issue(16'(APB_ADDR_READ), 1'b0, 16'h1234, 4, 16'hAAAA, 1);
    issue(16'h0100, 1'b0, 16'h0000, 100, 16'hBEEF, 0);
    issue(16'h0101, 1'b0, 16'h0000, 7, 16'hC0DE, 0);
    issue(16'h0102, 1'b0, 16'h0000, 8, 16'hD00D, 0);
    issue(16'h0010, 1'b1, 16'h1111, 0, 16'h0000, 0);
    issue(16'h0011, 1'b1, 16'h2222, 0, 16'h0000, 0);
    issue(16'h0012, 1'b0, 16'h3333, 0, 16'h4444, 0);
    for (int i = 0; i < 150; i++)
      issue(16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
            16'($urandom), int'($urandom_range(0, 3) >> 1));
    drain();
    issue(16'h0200, 1'b0, 16'h0000, 6, 16'h7777, 2);
    req_valid = 0;
    n = 0;
    while (!(M_PSELx && M_PENABLE) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reached_access", M_PSELx && M_PENABLE, 1);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("rst_psel", M_PSELx, 0);
    chk("rst_penable", M_PENABLE, 0);
    chk("rst_ready", req_ready, 0);
    sb.delete();
    sq.delete();
    have_prev = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    #1 chk("ready_after_midreset", req_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 20; i++)
      issue(16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
            16'($urandom), int'($urandom_range(0, 3) >> 1));
    drain();
    z_req_addr = 16'h0001;
    z_req_valid = 1;
    n = 0;
    while (!z_req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    hsz = cyc + 1;
    @(negedge clk);
    z_req_valid = 0;
    n = 0;
    while (!z_rsp_valid && n < LONG_WAIT + 50) begin
      @(negedge clk);
      n++;
    end
    chk("nto_rsp_valid", z_rsp_valid, 1);
    chk("nto_rsp_cycle", cyc, hsz + 2 + LONG_WAIT);
    chk("nto_rsp_err", z_rsp_err, 0);
    chk("nto_rsp_rdata", z_rsp_rdata, 16'h5A3C);
    @(negedge clk);
    chk("nto_rsp_pulse", z_rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 1000000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
